// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the mccomp MIPS subset: FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Optional illegal-instruction trap to a sticky HALT state when MC_ILLEGAL_TRAP_EN is defined.
module mc_ctrl #(
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         WDSel,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               EXTOp,
    output logic [1:0]         NPCOp,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               halt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(7);

    logic [2:0]         next_state;
    logic               is_rtype;
    logic               is_jr;
    logic               r_legal;
    logic               is_legal;
    logic [ALUOP_W-1:0] r_aluop;

    assign is_rtype = (Op == OP_RTYPE);
    assign is_jr    = is_rtype && (Funct == FN_JR);

    // R-type function decode; jr is legal but never reaches the ALU op path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        r_aluop = ALU_ADD;
        r_legal = 1'b1;
        case (Funct)
            FN_ADD:  r_aluop = ALU_ADD;
            FN_SUB:  r_aluop = ALU_SUB;
            FN_AND:  r_aluop = ALU_AND;
            FN_OR:   r_aluop = ALU_OR;
            FN_SLT:  r_aluop = ALU_SLT;
            FN_SLL:  r_aluop = ALU_SLL;
            FN_SRL:  r_aluop = ALU_SRL;
            FN_JR:   r_aluop = ALU_ADD;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (Op)
            OP_RTYPE: is_legal = r_legal;
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW: is_legal = 1'b1;
            default:      is_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        WDSel      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = ALU_ADD;
        EXTOp      = 1'b0;
        NPCOp      = 2'b00;

        case (state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target PC+4 + (sext(imm) << 2) is staged into ALUOut here.
                ALUSrcB = 2'b11;
                EXTOp   = 1'b1;
                if (!is_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_FETCH;
`endif
                end else if (Op == OP_J || Op == OP_JAL) begin
                    PCWrite    = 1'b1;
                    NPCOp      = 2'b10;
                    next_state = S_FETCH;
                    if (Op == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        WDSel    = 2'b10;
                    end
                end else begin
                    next_state = S_EXEC;
                end
            end

            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (is_rtype) begin
                    if (is_jr) begin
                        PCWrite    = 1'b1;
                        NPCOp      = 2'b11;
                        next_state = S_FETCH;
                    end else begin
                        ALUOp      = r_aluop;
                        next_state = S_WB;
                    end
                end else begin
                    case (Op)
                        OP_ADDI, OP_ORI, OP_LUI: begin
                            ALUSrcB    = 2'b10;
                            EXTOp      = (Op != OP_ORI);
                            ALUOp      = (Op == OP_ORI) ? ALU_OR :
                                         (Op == OP_LUI) ? ALU_LUI : ALU_ADD;
                            next_state = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            ALUSrcB    = 2'b10;
                            EXTOp      = 1'b1;
                            next_state = S_MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            ALUOp      = ALU_SUB;
                            NPCOp      = 2'b01;
                            PCWrite    = (Op == OP_BEQ) ? Zero : ~Zero;
                            next_state = S_FETCH;
                        end
                        default: next_state = S_FETCH;
                    endcase
                end
            end

            S_MEM: begin
                IorD     = 1'b1;
                MemWrite = (Op == OP_SW);
                if (mem_ready) next_state = (Op == OP_SW) ? S_FETCH : S_WB;
            end

            S_WB: begin
                RegWrite   = 1'b1;
                RegDst     = is_rtype ? 2'b01 : 2'b00;
                WDSel      = (Op == OP_LW) ? 2'b01 : 2'b00;
                next_state = S_FETCH;
            end

            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase

        // Reset abandons the instruction in flight: no write may leak out.
        if (rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign instr_done = !rst && (state != S_FETCH) && (next_state == S_FETCH);

`ifdef MC_ILLEGAL_TRAP_EN
    assign halt = !rst && (state == S_HALT);
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes one expected control vector per cycle, a monitor compares on negedge.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] regdst;
        logic [1:0] wdsel;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic       extop;
        logic [1:0] npc;
        logic       done;
        logic       halt;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        ctl_t  m;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, EXTOp, instr_done, halt;
    logic [1:0] RegDst, WDSel, ALUSrcB, NPCOp;
    logic [3:0] ALUOp;
    logic [2:0] state;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mc_ctrl #(.ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .EXTOp(EXTOp), .NPCOp(NPCOp),
        .state(state), .instr_done(instr_done), .halt(halt)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled mid-cycle, one expected vector per cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            ctl_t got;
            e   = sb_q.pop_front();
            got = {state, PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, WDSel,
                   ALUSrcA, ALUSrcB, ALUOp, EXTOp, NPCOp, instr_done, halt};
            check(e.name, got, e.v, e.m);
        end
    end

    task automatic check(input string name, input ctl_t got, input ctl_t exp, input ctl_t m);
        n_vec++;
        if (((got ^ exp) & m) !== '0) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, got, exp, m);
        end
    endtask

    function automatic ctl_t c_base(input logic [2:0] st);
        ctl_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input ctl_t e, input string name,
                        input logic ign_ext);
        exp_t x;
        rst       = r;
        Op        = op;
        Funct     = fn;
        Zero      = z;
        mem_ready = mr;
        x.v    = e;
        x.m    = '1;
        if (ign_ext) x.m.extop = 1'b0;
        x.name = name;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input logic mr, input string name);
        ctl_t e;
        e      = c_base(3'd0);
        e.srcb = 2'b01;
        e.irw  = mr;
        e.pcw  = mr;
        step(1'b0, op, fn, 1'b0, mr, e, {name, "_fetch"}, 1'b0);
    endtask

    task automatic do_decode(input logic [5:0] op, input logic [5:0] fn, input logic done, input string name);
        ctl_t e;
        e      = c_base(3'd1);
        e.srcb = 2'b11;
        e.done = done;
        step(1'b0, op, fn, 1'b0, 1'b1, e, {name, "_decode"}, 1'b1);
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [3:0] aluop, input string name);
        ctl_t e;
        do_fetch(6'h00, fn, 1'b1, name);
        do_decode(6'h00, fn, 1'b0, name);
        e = c_base(3'd2); e.srca = 1'b1; e.aluop = aluop;
        step(1'b0, 6'h00, fn, 1'b0, 1'b1, e, {name, "_exec"}, 1'b0);
        e = c_base(3'd4); e.regw = 1'b1; e.regdst = 2'b01; e.done = 1'b1;
        step(1'b0, 6'h00, fn, 1'b0, 1'b1, e, {name, "_wb"}, 1'b0);
    endtask

    task automatic run_i(input logic [5:0] op, input logic [3:0] aluop, input logic ext, input string name);
        ctl_t e;
        do_fetch(op, 6'h00, 1'b1, name);
        do_decode(op, 6'h00, 1'b0, name);
        e = c_base(3'd2); e.srca = 1'b1; e.srcb = 2'b10; e.aluop = aluop; e.extop = ext;
        step(1'b0, op, 6'h00, 1'b0, 1'b1, e, {name, "_exec"}, 1'b0);
        e = c_base(3'd4); e.regw = 1'b1; e.done = 1'b1;
        step(1'b0, op, 6'h00, 1'b0, 1'b1, e, {name, "_wb"}, 1'b0);
    endtask

    task automatic run_mem_exec(input logic [5:0] op, input string name);
        ctl_t e;
        do_fetch(op, 6'h00, 1'b1, name);
        do_decode(op, 6'h00, 1'b0, name);
        e = c_base(3'd2); e.srca = 1'b1; e.srcb = 2'b10; e.extop = 1'b1;
        step(1'b0, op, 6'h00, 1'b0, 1'b1, e, {name, "_exec"}, 1'b0);
    endtask

    task automatic run_lw(input int stalls);
        ctl_t e;
        run_mem_exec(6'h23, "lw");
        for (int i = 0; i < stalls; i++) begin
            e = c_base(3'd3); e.iord = 1'b1;
            step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, e, "lw_mem_wait", 1'b0);
        end
        e = c_base(3'd3); e.iord = 1'b1;
        step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, e, "lw_mem_ready", 1'b0);
        e = c_base(3'd4); e.regw = 1'b1; e.wdsel = 2'b01; e.done = 1'b1;
        step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, e, "lw_wb", 1'b0);
    endtask

    task automatic run_br(input logic [5:0] op, input logic z, input logic pcw, input string name);
        ctl_t e;
        do_fetch(op, 6'h00, 1'b1, name);
        do_decode(op, 6'h00, 1'b0, name);
        e = c_base(3'd2); e.srca = 1'b1; e.aluop = 4'd1; e.npc = 2'b01; e.pcw = pcw; e.done = 1'b1;
        step(1'b0, op, 6'h00, z, 1'b1, e, {name, "_exec"}, 1'b0);
    endtask

    task automatic run_jump(input logic [5:0] op, input logic link, input string name);
        ctl_t e;
        do_fetch(op, 6'h00, 1'b1, name);
        e = c_base(3'd1); e.srcb = 2'b11; e.pcw = 1'b1; e.npc = 2'b10; e.done = 1'b1;
        if (link) begin
            e.regw = 1'b1; e.regdst = 2'b10; e.wdsel = 2'b10;
        end
        step(1'b0, op, 6'h00, 1'b0, 1'b1, e, {name, "_decode"}, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fetch stall, then the add $3,$1,$2 walk (0x00221820).
        do_fetch(6'h00, 6'h20, 1'b0, "stall");
        run_r(6'h20, 4'd0, "add");
        run_r(6'h22, 4'd1, "sub");
        run_r(6'h2A, 4'd4, "slt");
        run_r(6'h02, 4'd6, "srl");
        run_i(6'h08, 4'd0, 1'b1, "addi");
        run_i(6'h0D, 4'd3, 1'b0, "ori");
        run_i(6'h0F, 4'd7, 1'b1, "lui");
        run_lw(2);

        run_mem_exec(6'h2B, "sw");
        e = c_base(3'd3); e.iord = 1'b1; e.memw = 1'b1;
        step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, e, "sw_mem_wait", 1'b0);
        e.done = 1'b1;
        step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, e, "sw_mem_ready", 1'b0);

        run_br(6'h04, 1'b1, 1'b1, "beq_taken");
        run_br(6'h04, 1'b0, 1'b0, "beq_not");
        run_br(6'h05, 1'b0, 1'b1, "bne_taken");

        do_fetch(6'h00, 6'h08, 1'b1, "jr");
        do_decode(6'h00, 6'h08, 1'b0, "jr");
        e = c_base(3'd2); e.srca = 1'b1; e.pcw = 1'b1; e.npc = 2'b11; e.done = 1'b1;
        step(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, e, "jr_exec", 1'b0);

        run_jump(6'h02, 1'b0, "j");
        run_jump(6'h03, 1'b1, "jal");

        // Reset asserted while sw is stalled in MEM: state drops to FETCH before the next edge.
        run_mem_exec(6'h2B, "sw_rst");
        e = c_base(3'd3); e.iord = 1'b1; e.memw = 1'b1;
        step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, e, "sw_rst_mem", 1'b0);
        e = c_base(3'd0); e.srcb = 2'b01;
        step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, e, "rst_in_mem", 1'b0);
        do_fetch(6'h2B, 6'h00, 1'b0, "after_rst");

`ifndef MC_ILLEGAL_TRAP_EN
        do_fetch(6'h00, 6'h3F, 1'b1, "bad_funct");
        do_decode(6'h00, 6'h3F, 1'b1, "bad_funct");
        do_fetch(6'h3F, 6'h00, 1'b1, "bad_op");
        do_decode(6'h3F, 6'h00, 1'b1, "bad_op");
        do_fetch(6'h3F, 6'h00, 1'b0, "bad_op_after");
`else
        do_fetch(6'h3F, 6'h00, 1'b1, "bad_op");
        do_decode(6'h3F, 6'h00, 1'b0, "bad_op");
        for (int i = 0; i < 10; i++) begin
            e = c_base(3'd5); e.halt = 1'b1;
            step(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, e, "halt_hold", 1'b0);
        end
        e = c_base(3'd0); e.srcb = 2'b01;
        step(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, e, "halt_rst", 1'b0);
        do_fetch(6'h00, 6'h20, 1'b0, "halt_after_rst");
`endif

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
